// File: rtl/tdt_dmi_hs_rx.sv
// rtl/tdt_dmi_hs_rx.sv - dst-side toggle handshake receiver for DMI words.
// Optional parity check on capture enabled by TDT_DMI_HS_RX_PARITY_EN.
module tdt_dmi_hs_rx #(
   parameter int SYNC_NUM = 3,
   parameter int DATA_W   = 41
) (
   input  logic              dst_clk,
   input  logic              dst_rst_b,
   input  logic              src_req_tgl,
   input  logic [DATA_W-1:0] src_data,
   output logic              dst_vld,
   output logic [DATA_W-1:0] dst_data,
   input  logic              dst_rdy,
   output logic              dst_ack_tgl,
   output logic              dst_ovf,
   input  logic              dst_ovf_clr
`ifdef TDT_DMI_HS_RX_PARITY_EN
   ,
   input  logic              src_par,
   output logic              dst_perr
`endif
);

   typedef enum logic {
      IDLE  = 1'b0,
      VALID = 1'b1
   } state_t;

   state_t              state, state_d;
   logic [SYNC_NUM-1:0] sync_q;
   logic                req_sync;
   logic                req_seen, seen_d;
   logic                req_new;
   logic                vld_d, ack_d, ovf_d;
   logic [DATA_W-1:0]   data_d;
`ifdef TDT_DMI_HS_RX_PARITY_EN
   logic                perr_d;
`endif

   assign req_sync = sync_q[SYNC_NUM-1];
   assign req_new  = req_sync != req_seen;

   always_comb begin
      state_d = state;
      vld_d   = dst_vld;
      data_d  = dst_data;
      seen_d  = req_seen;
      ack_d   = dst_ack_tgl;
      ovf_d   = dst_ovf & ~dst_ovf_clr;
`ifdef TDT_DMI_HS_RX_PARITY_EN
      perr_d  = dst_perr & ~dst_ovf_clr;
`endif
      case (state)
         IDLE: begin
            if (req_new) begin
               data_d  = src_data;
               seen_d  = req_sync;
               vld_d   = 1'b1;
               state_d = VALID;
`ifdef TDT_DMI_HS_RX_PARITY_EN
               if (^{src_data, src_par}) perr_d = 1'b1;
`endif
            end
         end
         VALID: begin
            // A toggle arriving while a word is held stays pending in req_new
            if (req_new) ovf_d = 1'b1;
            if (dst_rdy) begin
               vld_d   = 1'b0;
               ack_d   = ~dst_ack_tgl;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge dst_clk or negedge dst_rst_b) begin
      if (!dst_rst_b) begin
         state       <= IDLE;
         sync_q      <= '0;
         req_seen    <= 1'b0;
         dst_vld     <= 1'b0;
         dst_data    <= '0;
         dst_ack_tgl <= 1'b0;
         dst_ovf     <= 1'b0;
`ifdef TDT_DMI_HS_RX_PARITY_EN
         dst_perr    <= 1'b0;
`endif
      end else begin
         state       <= state_d;
         sync_q      <= {sync_q[SYNC_NUM-2:0], src_req_tgl};
         req_seen    <= seen_d;
         dst_vld     <= vld_d;
         dst_data    <= data_d;
         dst_ack_tgl <= ack_d;
         dst_ovf     <= ovf_d;
`ifdef TDT_DMI_HS_RX_PARITY_EN
         dst_perr    <= perr_d;
`endif
      end
   end

endmodule

// File: tb/tb_tdt_dmi_hs_rx.sv
// tb/tb_tdt_dmi_hs_rx.sv - scoreboard bench for tdt_dmi_hs_rx.
module tb_tdt_dmi_hs_rx;
   localparam int DATA_W = 41;

   logic              dst_clk = 1'b0;
   logic              dst_rst_b;
   logic              src_req_tgl;
   logic [DATA_W-1:0] src_data;
   logic              dst_vld;
   logic [DATA_W-1:0] dst_data;
   logic              dst_rdy;
   logic              dst_ack_tgl;
   logic              dst_ovf;
   logic              dst_ovf_clr;
`ifdef TDT_DMI_HS_RX_PARITY_EN
   logic              src_par;
   logic              dst_perr;
`endif

   int n_cmp  = 0;
   int n_fail = 0;
   logic [DATA_W-1:0] exp_q[$];

   tdt_dmi_hs_rx #(.SYNC_NUM(3), .DATA_W(DATA_W)) dut (
      .dst_clk     (dst_clk),
      .dst_rst_b   (dst_rst_b),
      .src_req_tgl (src_req_tgl),
      .src_data    (src_data),
      .dst_vld     (dst_vld),
      .dst_data    (dst_data),
      .dst_rdy     (dst_rdy),
      .dst_ack_tgl (dst_ack_tgl),
      .dst_ovf     (dst_ovf),
      .dst_ovf_clr (dst_ovf_clr)
`ifdef TDT_DMI_HS_RX_PARITY_EN
      ,
      .src_par     (src_par),
      .dst_perr    (dst_perr)
`endif
   );

   always #5 dst_clk = ~dst_clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge dst_clk);
      #1;
   endtask

   task automatic send(input logic [DATA_W-1:0] w, input bit expect_delivery);
      src_data    = w;
      src_req_tgl = ~src_req_tgl;
      if (expect_delivery) exp_q.push_back(w);
   endtask

   task automatic wait_vld(input string name);
      int n = 0;
      while (!dst_vld && n < 12) begin
         tick();
         n++;
      end
      chk(name, 64'(dst_vld), 64'd1);
   endtask

   task automatic do_reset();
      dst_rst_b   = 1'b0;
      src_req_tgl = 1'b0;
      dst_rdy     = 1'b0;
      dst_ovf_clr = 1'b0;
      src_data    = '0;
      repeat (3) tick();
      dst_rst_b = 1'b1;
   endtask

   // Scoreboard monitor: every accepted word must match the oldest expected one
   always @(negedge dst_clk) begin
      if (dst_rst_b && dst_vld && dst_rdy) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got %0h expected none", dst_data);
         end else begin
            logic [DATA_W-1:0] e;
            e = exp_q.pop_front();
            if (dst_data !== e) begin
               n_fail++;
               $display("FAIL sb_data: got %0h expected %0h", dst_data, e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
`ifdef TDT_DMI_HS_RX_PARITY_EN
      src_par = 1'b0;
`endif
      // 1: reset state held for 20 cycles
      do_reset();
      ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (dst_vld || dst_ack_tgl || dst_ovf || dst_data != '0) ok = 1'b0;
      end
      chk("reset_idle_20", 64'(ok), 64'd1);
      chk("reset_data", 64'(dst_data), 64'd0);

      // 2: latency, vld after edge 4, ack flips on edge 5
      dst_rdy = 1'b1;
      send(41'h1_2345_6789, 1'b1);
      for (int e = 1; e <= 3; e++) begin
         tick();
         chk($sformatf("lat_vld_lo_e%0d", e), 64'(dst_vld), 64'd0);
      end
      tick();
      chk("lat_vld_e4", 64'(dst_vld), 64'd1);
      chk("lat_data_e4", 64'(dst_data), 64'h1_2345_6789);
      chk("lat_ack_e4", 64'(dst_ack_tgl), 64'd0);
      tick();
      chk("lat_ack_e5", 64'(dst_ack_tgl), 64'd1);
      chk("lat_vld_e5", 64'(dst_vld), 64'd0);

      // 3: backpressure hold
      dst_rdy = 1'b0;
      send(41'h0_ABCD_EF01, 1'b1);
      wait_vld("bp_vld");
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (!dst_vld || dst_data != 41'h0_ABCD_EF01 || !dst_ack_tgl) ok = 1'b0;
      end
      chk("bp_hold", 64'(ok), 64'd1);
      dst_rdy = 1'b1;
      tick();
      chk("bp_ack", 64'(dst_ack_tgl), 64'd0);
      chk("bp_vld_lo", 64'(dst_vld), 64'd0);
      tick();
      chk("bp_ack_single", 64'(dst_ack_tgl), 64'd0);

      // 4: overflow, set beats clear, pending word serviced after consume
      dst_rdy = 1'b0;
      send(41'h1_FFFF_0000, 1'b1);
      wait_vld("ovf_vld");
      send(41'h0_0000_5A5A, 1'b1);
      repeat (5) tick();
      chk("ovf_set", 64'(dst_ovf), 64'd1);
      chk("ovf_data_held", 64'(dst_data), 64'h1_FFFF_0000);
      dst_ovf_clr = 1'b1;
      tick();
      dst_ovf_clr = 1'b0;
      chk("ovf_set_wins", 64'(dst_ovf), 64'd1);
      dst_rdy = 1'b1;
      tick();
      chk("ovf_consume_a", 64'(dst_vld), 64'd0);
      chk("ovf_ack_a", 64'(dst_ack_tgl), 64'd1);
      tick();
      chk("ovf_vld_b", 64'(dst_vld), 64'd1);
      chk("ovf_data_b", 64'(dst_data), 64'h0_0000_5A5A);
      tick();
      chk("ovf_ack_b", 64'(dst_ack_tgl), 64'd0);
      chk("ovf_still", 64'(dst_ovf), 64'd1);
      dst_ovf_clr = 1'b1;
      tick();
      dst_ovf_clr = 1'b0;
      chk("ovf_clr", 64'(dst_ovf), 64'd0);

      // 5: async reset while holding a word
      send(41'h0_1111_2222, 1'b1);
      wait_vld("rst_pre_vld");
      tick();
      chk("rst_pre_ack", 64'(dst_ack_tgl), 64'd1);
      dst_rdy = 1'b0;
      send(41'h1_3333_4444, 1'b0);
      wait_vld("rst_hold_vld");
      #2;
      dst_rst_b   = 1'b0;
      src_req_tgl = 1'b0;
      #1;
      chk("rst_async_vld", 64'(dst_vld), 64'd0);
      chk("rst_async_ack", 64'(dst_ack_tgl), 64'd0);
      tick();
      dst_rst_b = 1'b1;
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (dst_vld || dst_data != '0) ok = 1'b0;
      end
      chk("rst_no_spurious", 64'(ok), 64'd1);

`ifdef TDT_DMI_HS_RX_PARITY_EN
      // 6: parity error flagged, word still delivered
      do_reset();
      dst_rdy = 1'b1;
      src_par = 1'b0;
      send(41'h1, 1'b1);
      wait_vld("par_vld");
      chk("par_err", 64'(dst_perr), 64'd1);
      tick();
      do_reset();
      dst_rdy = 1'b1;
      src_par = 1'b1;
      send(41'h1, 1'b1);
      wait_vld("par_ok_vld");
      chk("par_ok", 64'(dst_perr), 64'd0);
      tick();
`endif

      tick();
      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
